// File: rtl/diff_io_seq.sv
// Power-up/power-down sequencer for a bank of differential I/O channels (I_BUF_DS -> DFFRE -> O_BUFT_DS).
// Optional saturating abort counter on fault_cnt_o when DIFF_IO_SEQ_FAULT_CNT_EN is defined.
module diff_io_seq #(
    parameter int NUM_CH        = 4,
    parameter int SETTLE_CYCLES = 16,
    parameter int CNT_W         = 8
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              start_i,
    input  logic              stop_i,
    input  logic              clk_ok_i,
    output logic [NUM_CH-1:0] ibuf_en_o,
    output logic              capture_en_o,
    output logic              obuf_oe_o,
    output logic              ready_o,
    output logic              busy_o,
    output logic              fault_o
`ifdef DIFF_IO_SEQ_FAULT_CNT_EN
    ,
    output logic [7:0]        fault_cnt_o
`endif
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EN_IN    = 3'd1,
        FLUSH    = 3'd2,
        RUN      = 3'd3,
        SHUT_OUT = 3'd4,
        SHUT_CAP = 3'd5,
        SHUT_IN  = 3'd6
    } state_e;

    localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  FLUSH_LAST  = CNT_W'(1);
    localparam logic [NUM_CH-1:0] ALL_ON      = '1;
    localparam logic [NUM_CH-1:0] CH0_ON      = NUM_CH'(1);

    state_e            state_q, state_d;
    logic [NUM_CH-1:0] ibuf_q, ibuf_d;
    logic              cap_q, cap_d;
    logic              oe_q, oe_d;
    logic              fault_q, fault_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [1:0]        rst_sync_q;
    logic              rst_n;
    logic              up_phase;
    logic              abort;

    // Reset asserts asynchronously but releases on a clock edge.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rst_sync_q <= 2'b00;
        else         rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
    assign rst_n = rst_sync_q[1];

    assign up_phase = (state_q == EN_IN) || (state_q == FLUSH) || (state_q == RUN);
    assign abort    = up_phase && (stop_i || !clk_ok_i);

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ibuf_q  <= '0;
            cap_q   <= 1'b0;
            oe_q    <= 1'b0;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            ibuf_q  <= ibuf_d;
            cap_q   <= cap_d;
            oe_q    <= oe_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_i && !stop_i && clk_ok_i) state_d = EN_IN;
            EN_IN: begin
                if (abort)                                           state_d = SHUT_OUT;
                else if (cnt_q == SETTLE_LAST && ibuf_q == ALL_ON)   state_d = FLUSH;
            end
            FLUSH: begin
                if (abort)                    state_d = SHUT_OUT;
                else if (cnt_q == FLUSH_LAST) state_d = RUN;
            end
            RUN:      if (abort) state_d = SHUT_OUT;
            // Skip the capture step when the capture registers were never enabled.
            SHUT_OUT: state_d = cap_q ? SHUT_CAP : SHUT_IN;
            SHUT_CAP: state_d = SHUT_IN;
            SHUT_IN:  if (ibuf_q == '0) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        ibuf_d  = ibuf_q;
        cap_d   = cap_q;
        oe_d    = oe_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (state_d == EN_IN) begin
                    ibuf_d  = CH0_ON;
                    cnt_d   = '0;
                    fault_d = 1'b0;
                end
            end
            EN_IN, FLUSH, RUN: begin
                if (abort) begin
                    oe_d  = 1'b0;
                    cnt_d = '0;
                    if (!clk_ok_i) fault_d = 1'b1;
                end else if (state_q == EN_IN) begin
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_d = '0;
                        if (ibuf_q == ALL_ON) cap_d = 1'b1;
                        else                  ibuf_d = (ibuf_q << 1) | CH0_ON;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end else if (state_q == FLUSH) begin
                    if (cnt_q == FLUSH_LAST) begin
                        oe_d  = 1'b1;
                        cnt_d = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            // The enable mask is contiguous, so a right shift drops the highest set bit.
            SHUT_OUT: begin
                if (cap_q) cap_d  = 1'b0;
                else       ibuf_d = ibuf_q >> 1;
            end
            SHUT_CAP, SHUT_IN: ibuf_d = ibuf_q >> 1;
            default: begin
                ibuf_d = '0;
                cap_d  = 1'b0;
                oe_d   = 1'b0;
            end
        endcase
    end

    assign ibuf_en_o    = ibuf_q;
    assign capture_en_o = cap_q;
    assign obuf_oe_o    = oe_q;
    assign ready_o      = (state_q == RUN);
    assign busy_o       = (state_q != IDLE) && (state_q != RUN);
    assign fault_o      = fault_q;

`ifdef DIFF_IO_SEQ_FAULT_CNT_EN
    logic [7:0] fault_cnt_q;
    logic       clk_abort;

    assign clk_abort = up_phase && !clk_ok_i;

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n)                                 fault_cnt_q <= 8'd0;
        else if (clk_abort && fault_cnt_q != 8'hFF) fault_cnt_q <= fault_cnt_q + 8'd1;
    end
    assign fault_cnt_o = fault_cnt_q;
`endif

    a_oe_needs_cap: assert property (@(posedge clk_i) disable iff (!rst_n)
        oe_q |-> cap_q);
    a_cap_needs_all_in: assert property (@(posedge clk_i) disable iff (!rst_n)
        cap_q |-> (ibuf_q == ALL_ON));
    a_mask_contiguous: assert property (@(posedge clk_i) disable iff (!rst_n)
        ((ibuf_q + CH0_ON) & ibuf_q) == '0);

endmodule

// File: tb/tb_diff_io_seq.sv
// Bench for diff_io_seq: directed timelines plus random start/stop/clock-loss traffic
// compared cycle by cycle against an elapsed-time / teardown-list reference model.
module tb_diff_io_seq;
    localparam int N = 4;
    localparam int S = 16;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0, stop = 1'b0, clk_ok = 1'b1;
    logic [N-1:0] ibuf_en;
    logic         capture_en, obuf_oe, ready, busy, fault;
`ifdef DIFF_IO_SEQ_FAULT_CNT_EN
    logic [7:0]   fault_cnt;
`endif

    diff_io_seq #(.NUM_CH(N), .SETTLE_CYCLES(S), .CNT_W(8)) dut (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop), .clk_ok_i(clk_ok),
        .ibuf_en_o(ibuf_en), .capture_en_o(capture_en), .obuf_oe_o(obuf_oe),
        .ready_o(ready), .busy_o(busy), .fault_o(fault)
`ifdef DIFF_IO_SEQ_FAULT_CNT_EN
        , .fault_cnt_o(fault_cnt)
`endif
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_chk  = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: idle, up (elapsed cycles since START), or down (list of remaining snapshots).
    typedef struct { bit oe; bit cap; int ch; } snap_t;
    int    m_mode = 0;
    int    m_j    = 0;
    snap_t m_q[$];
    bit    m_fault = 0;
    int    m_fcnt  = 0;

    function automatic int up_ch(input int j);
        int c = j / S + 1;
        return (c > N) ? N : c;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_j = 0; m_q.delete(); m_fault = 0; m_fcnt = 0;
    endtask

    task automatic model_edge(input bit st, input bit sp, input bit ok);
        int c;
        bit cp;
        case (m_mode)
            0: if (st && !sp && ok) begin m_mode = 1; m_j = 0; m_fault = 0; end
            1: begin
                if (sp || !ok) begin
                    c  = up_ch(m_j);
                    cp = (m_j >= N*S);
                    m_q.delete();
                    m_q.push_back('{oe: 1'b0, cap: cp, ch: c});
                    if (cp) m_q.push_back('{oe: 1'b0, cap: 1'b0, ch: c});
                    for (int k = c - 1; k >= 0; k--) m_q.push_back('{oe: 1'b0, cap: 1'b0, ch: k});
                    m_mode = 2;
                    if (!ok) begin
                        m_fault = 1;
                        if (m_fcnt < 255) m_fcnt++;
                    end
                end else begin
                    m_j++;
                end
            end
            default: begin
                void'(m_q.pop_front());
                if (m_q.size() == 0) m_mode = 0;
            end
        endcase
    endtask

    task automatic check_outputs();
        int e_ch = 0, e_cap = 0, e_oe = 0, e_rdy = 0, e_busy = 0;
        if (m_mode == 1) begin
            e_ch   = up_ch(m_j);
            e_cap  = (m_j >= N*S) ? 1 : 0;
            e_oe   = (m_j >= N*S + 2) ? 1 : 0;
            e_rdy  = e_oe;
            e_busy = 1 - e_oe;
        end else if (m_mode == 2) begin
            e_ch   = m_q[0].ch;
            e_cap  = int'(m_q[0].cap);
            e_oe   = int'(m_q[0].oe);
            e_busy = 1;
        end
        chk("ibuf_en",    int'(ibuf_en),    (1 << e_ch) - 1);
        chk("capture_en", int'(capture_en), e_cap);
        chk("obuf_oe",    int'(obuf_oe),    e_oe);
        chk("ready",      int'(ready),      e_rdy);
        chk("busy",       int'(busy),       e_busy);
        chk("fault",      int'(fault),      int'(m_fault));
`ifdef DIFF_IO_SEQ_FAULT_CNT_EN
        chk("fault_cnt",  int'(fault_cnt),  m_fcnt);
`endif
    endtask

    task automatic step(input bit st, input bit sp, input bit ok);
        start = st; stop = sp; clk_ok = ok;
        @(posedge clk);
        model_edge(st, sp, ok);
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b1);
    endtask

    // Asserts reset mid-cycle, checks outputs dropped at once, then releases.
    task automatic do_reset();
        start = 1'b0; stop = 1'b0; clk_ok = 1'b1;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3);
    endtask

    initial begin
        #2;
        do_reset();

        // Bring-up with a redundant START at t=10, then STOP in RUN.
        step(1'b1, 1'b0, 1'b1);
        for (int t = 1; t <= 70; t++) step(t == 10, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        idle(8);

        // START+STOP together, START with no valid clock, STOP in IDLE.
        step(1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        idle(2);

        // Clock loss at t=20, fault held, then cleared by the next START.
        step(1'b1, 1'b0, 1'b1);
        idle(19);
        step(1'b0, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        idle(5);
        step(1'b0, 1'b1, 1'b1);
        idle(6);

        // Reset at t=66, then a clean bring-up.
        step(1'b1, 1'b0, 1'b1);
        idle(65);
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        idle(70);
        step(1'b0, 1'b0, 1'b0);
        idle(10);

`ifdef DIFF_IO_SEQ_FAULT_CNT_EN
        for (int a = 0; a < 300; a++) begin
            step(1'b1, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b1);
            step(1'b0, 1'b0, 1'b0);
            idle(5);
        end
`endif

        for (int i = 0; i < 4000; i++)
            step($urandom_range(0, 15) == 0, $urandom_range(0, 199) == 0,
                 $urandom_range(0, 299) != 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
